// File: rtl/instruction_fetch.sv
// Multicycle instruction-fetch stage: owns the PC, reads instruction memory over req/ack,
// and presents the latched word to register fetch under valid/ready. Redirects may load a new PC.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        rf_ready,
    output logic [31:0] if_instruction,
    output logic [5:0]  if_opcode,
    output logic [5:0]  if_funct,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fault,
    output logic [31:0] fetch_count,
    output logic [1:0]  debug_state
);

    // Handshakes: a memory word transfers on an edge where imem_req && imem_ack;
    // an instruction transfers to register fetch on an edge where if_valid && rf_ready.
    typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, HALT = 2'd2} state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic        valid_next, fault_next;
    logic [31:0] instr_next, ipc_next, ipc4_next, count_next;

    assign imem_req    = (state == FETCH) && rst_n;
    assign imem_addr   = pc;
    assign if_opcode   = if_instruction[31:26];
    assign if_funct    = if_instruction[5:0];
    assign debug_state = state;

    always_comb begin
        state_next = state;
        pc_next    = pc;
        valid_next = if_valid;
        fault_next = fault;
        instr_next = if_instruction;
        ipc_next   = if_pc;
        ipc4_next  = if_pc_plus4;
        count_next = fetch_count;

        // A consumer handshake in the same cycle as a redirect still counts.
        if (state == HOLD && if_valid && rf_ready)
            count_next = fetch_count + 32'd1;

        case (state)
            FETCH, HOLD: begin
                if (redirect) begin
                    valid_next = 1'b0;
                    if (redirect_pc[1:0] == 2'b00) begin
                        pc_next    = redirect_pc;
                        state_next = FETCH;
                    end else begin
                        fault_next = 1'b1;
                        state_next = HALT;
                    end
                end else if (state == FETCH) begin
                    if (imem_ack) begin
                        instr_next = imem_rdata;
                        ipc_next   = pc;
                        ipc4_next  = pc + 32'd4;
                        valid_next = 1'b1;
                        pc_next    = pc + 32'd4;
                        state_next = HOLD;
                    end
                end else if (rf_ready) begin
                    valid_next = 1'b0;
                    state_next = FETCH;
                end
            end
            default: begin
                valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= FETCH;
            pc             <= RESET_PC;
            if_valid       <= 1'b0;
            if_instruction <= 32'h0;
            if_pc          <= 32'h0;
            if_pc_plus4    <= 32'h0;
            fault          <= 1'b0;
            fetch_count    <= 32'h0;
        end else begin
            state          <= state_next;
            pc             <= pc_next;
            if_valid       <= valid_next;
            if_instruction <= instr_next;
            if_pc          <= ipc_next;
            if_pc_plus4    <= ipc4_next;
            fault          <= fault_next;
            fetch_count    <= count_next;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: reset, fetch/handshake timing, wait states,
// consumer stall, redirects, PC wrap and misaligned-redirect halt.
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        rf_ready;
    logic [31:0] if_instruction;
    logic [5:0]  if_opcode;
    logic [5:0]  if_funct;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fault;
    logic [31:0] fetch_count;
    logic [1:0]  debug_state;

    int checks = 0;
    int errors = 0;

    instruction_fetch #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .rf_ready(rf_ready),
        .if_instruction(if_instruction), .if_opcode(if_opcode), .if_funct(if_funct),
        .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .fault(fault), .fetch_count(fetch_count), .debug_state(debug_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; rf_ready = 1'b0;
        redirect = 1'b0; redirect_pc = 32'h0;
        step(); step();
        check("rst_valid", {31'b0, if_valid}, 32'h0);
        check("rst_fault", {31'b0, fault}, 32'h0);
        check("rst_count", fetch_count, 32'h0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_state", {30'b0, debug_state}, 32'h0);

        // First request appears in the first cycle with rst_n high.
        rst_n = 1'b1;
        #1;
        check("first_req", {31'b0, imem_req}, 32'h1);
        check("first_addr", imem_addr, 32'h0000_0100);
        imem_ack = 1'b1; imem_rdata = 32'h8C22_0004; rf_ready = 1'b1;
        step();
        check("f1_valid", {31'b0, if_valid}, 32'h1);
        check("f1_opcode", {26'b0, if_opcode}, 32'h0000_0023);
        check("f1_funct", {26'b0, if_funct}, 32'h0000_0004);
        check("f1_pc", if_pc, 32'h0000_0100);
        check("f1_pc4", if_pc_plus4, 32'h0000_0104);
        check("f1_req_hold", {31'b0, imem_req}, 32'h0);
        check("f1_count_before", fetch_count, 32'h0);
        imem_ack = 1'b0;
        step();
        check("f1_count", fetch_count, 32'h1);
        check("f1_next_addr", imem_addr, 32'h0000_0104);
        check("f1_valid_drop", {31'b0, if_valid}, 32'h0);

        // Three wait-state cycles.
        for (int i = 0; i < 3; i++) begin
            step();
            check("ws_req", {31'b0, imem_req}, 32'h1);
            check("ws_addr", imem_addr, 32'h0000_0104);
            check("ws_valid", {31'b0, if_valid}, 32'h0);
        end
        imem_ack = 1'b1; imem_rdata = 32'h0000_0020; rf_ready = 1'b0;
        step();
        check("ws_valid_rise", {31'b0, if_valid}, 32'h1);
        check("ws_instr", if_instruction, 32'h0000_0020);
        check("ws_pc", if_pc, 32'h0000_0104);
        imem_ack = 1'b0;

        // Consumer stall for five cycles.
        for (int i = 0; i < 5; i++) begin
            step();
            check("st_valid", {31'b0, if_valid}, 32'h1);
            check("st_instr", if_instruction, 32'h0000_0020);
            check("st_funct", {26'b0, if_funct}, 32'h0000_0020);
            check("st_pc4", if_pc_plus4, 32'h0000_0108);
            check("st_req", {31'b0, imem_req}, 32'h0);
            check("st_count", fetch_count, 32'h1);
        end
        rf_ready = 1'b1;
        step();
        check("st_release_count", fetch_count, 32'h2);
        check("st_release_req", {31'b0, imem_req}, 32'h1);
        check("st_release_addr", imem_addr, 32'h0000_0108);

        // Redirect in HOLD coincident with rf_ready.
        imem_ack = 1'b1; imem_rdata = 32'h1111_2222; rf_ready = 1'b0;
        step();
        check("rh_pre_valid", {31'b0, if_valid}, 32'h1);
        imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0200; rf_ready = 1'b1;
        step();
        check("rh_valid", {31'b0, if_valid}, 32'h0);
        check("rh_count", fetch_count, 32'h3);
        check("rh_addr", imem_addr, 32'h0000_0200);
        check("rh_req", {31'b0, imem_req}, 32'h1);

        // Redirect in FETCH with coincident ack: that word is dropped.
        redirect_pc = 32'h0000_0300; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; rf_ready = 1'b0;
        step();
        check("rf_valid", {31'b0, if_valid}, 32'h0);
        check("rf_addr", imem_addr, 32'h0000_0300);
        check("rf_instr_kept", if_instruction, 32'h1111_2222);
        redirect = 1'b0; imem_rdata = 32'h1234_5678; rf_ready = 1'b1;
        step();
        check("rf_new_instr", if_instruction, 32'h1234_5678);
        check("rf_new_pc", if_pc, 32'h0000_0300);
        imem_ack = 1'b0;
        step();
        check("rf_count", fetch_count, 32'h4);
        check("rf_next_addr", imem_addr, 32'h0000_0304);

        // PC wrap at the top of the address space.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        check("wr_addr", imem_addr, 32'hFFFF_FFFC);
        redirect = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hAAAA_5555; rf_ready = 1'b0;
        step();
        check("wr_pc", if_pc, 32'hFFFF_FFFC);
        check("wr_pc4", if_pc_plus4, 32'h0);
        imem_ack = 1'b0; rf_ready = 1'b1;
        step();
        check("wr_next_addr", imem_addr, 32'h0);
        check("wr_count", fetch_count, 32'h5);

        // Misaligned redirect halts the stage.
        redirect = 1'b1; redirect_pc = 32'h0000_0202;
        step();
        check("mis_fault", {31'b0, fault}, 32'h1);
        check("mis_req", {31'b0, imem_req}, 32'h0);
        check("mis_valid", {31'b0, if_valid}, 32'h0);
        check("mis_pc_kept", imem_addr, 32'h0);
        check("mis_state", {30'b0, debug_state}, 32'h2);
        redirect = 1'b0; imem_ack = 1'b1; rf_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("halt_fault", {31'b0, fault}, 32'h1);
            check("halt_req", {31'b0, imem_req}, 32'h0);
            check("halt_valid", {31'b0, if_valid}, 32'h0);
        end
        redirect = 1'b1; redirect_pc = 32'h0000_0400;
        step();
        check("halt_redirect_ignored", imem_addr, 32'h0);
        check("halt_redirect_req", {31'b0, imem_req}, 32'h0);
        redirect = 1'b0; imem_ack = 1'b0; rf_ready = 1'b0;

        // One reset edge clears the fault and restarts at RESET_PC.
        rst_n = 1'b0;
        step();
        check("rr_fault", {31'b0, fault}, 32'h0);
        check("rr_count", fetch_count, 32'h0);
        check("rr_req_low", {31'b0, imem_req}, 32'h0);
        rst_n = 1'b1;
        #1;
        check("rr_req", {31'b0, imem_req}, 32'h1);
        check("rr_addr", imem_addr, 32'h0000_0100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Multicycle instruction-fetch stage that sits directly upstream of the register-fetch/decode stage. It owns the program counter and issues word reads to instruction memory over a request/acknowledge handshake. It latches the returned word and PC into an output register and presents them, pre-split into opcode and function fields, to register fetch under a valid/ready handshake. It also accepts PC redirects for branches and jumps, and flags misaligned redirect targets.

## Interface
- RESET_PC, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- imem_req  out  1  instruction-memory read request.
- imem_addr  out  32  byte address of the read; always equals internal PC.
- imem_ack  in  1  memory has data on imem_rdata this cycle.
- imem_rdata  in  32  instruction word; sampled only when imem_req && imem_ack.
- if_valid  out  1  output register holds an instruction for register fetch.
- rf_ready  in  1  register fetch accepts the instruction this cycle.
- if_instruction  out  32  latched instruction word.
- if_opcode  out  6  if_instruction[31:26].
- if_funct  out  6  if_instruction[5:0].
- if_pc  out  32  address the instruction was fetched from.
- if_pc_plus4  out  32  if_pc + 4, modulo 2^32.
- redirect  in  1  load new PC (branch/jump taken).
- redirect_pc  in  32  new PC; sampled only when redirect=1.
- fault  out  1  sticky misaligned-redirect flag.
- fetch_count  out  32  number of instructions accepted by register fetch.

## Operation
- States: FETCH, HOLD, HALT. Reset state is FETCH.
- Reset values while rst_n=0 at an edge:
  - pc = RESET_PC, state = FETCH.
  - if_valid, if_instruction, if_pc, if_pc_plus4 and fault = 0.
  - fetch_count = 0.
- imem_req = (state==FETCH) && rst_n. imem_addr = pc.
- FETCH:
  - imem_req stays high and imem_addr stays stable until imem_ack.
  - On imem_ack, register if_instruction=imem_rdata, if_pc=pc, if_pc_plus4=pc+4 and if_valid=1. Set pc=pc+4 and go to HOLD.
- HOLD:
  - if_valid=1; all if_* outputs stay stable until the handshake.
  - On rf_ready, set if_valid=0, increment fetch_count and go to FETCH.
- HALT: imem_req=0 and if_valid=0. Only reset leaves HALT.
- Redirect has priority over every other event in FETCH and HOLD; it is ignored in HALT.
  - If redirect_pc[1:0]==0: pc=redirect_pc, if_valid=0, state=FETCH.
  - An imem_ack in the same cycle is discarded. The memory transaction still completes and is not replayed.
  - If rf_ready && if_valid in the same cycle, the handshake counts: fetch_count increments.
  - If redirect_pc[1:0]!=0: fault=1, if_valid=0, state=HALT, pc unchanged.
- Arithmetic:
  - pc+4 and fetch_count wrap modulo 2^32 with no flag.
  - pc 32'hFFFF_FFFC advances to 32'h0000_0000.
- rf_ready while if_valid=0 has no effect.

## Timing
- Fetch latency: ack at edge N gives if_valid=1 after edge N. Register fetch sees the instruction in cycle N+1.
- With ack in the same cycle as the request:
  - Request in cycle N, valid in N+1.
  - If accepted in N+1, the next request is in N+2.
  - Peak throughput is one instruction per 2 cycles.
- Each wait-state cycle (req high, ack low) adds one cycle of latency.
- A redirect at edge N puts the new imem_addr on the bus in cycle N+1, with imem_req=1.
- First request after reset release: the first cycle with rst_n=1, at address RESET_PC.
- Reset mid-operation:
  - A pending request is abandoned and state clears at that edge.
  - The memory side must tolerate req dropping before ack.
- All outputs are registered, except imem_req/imem_addr (decoded from state/pc) and if_opcode/if_funct (slices of a register).

## Test plan
- Reset with RESET_PC=32'h100; ack same cycle, rdata=32'h8C22_0004; rf_ready=1:
  - imem_addr=32'h100 in the first cycle after reset.
  - Next cycle: if_valid=1, if_opcode=6'b100011, if_pc=32'h100, if_pc_plus4=32'h104.
  - Next imem_addr=32'h104; fetch_count=1.
- Memory wait states:
  - Hold imem_ack low for 3 cycles: imem_req stays 1 and imem_addr stays stable.
  - if_valid rises the cycle after ack.
- Consumer stall:
  - Hold rf_ready=0 for 5 cycles with if_valid=1: outputs stay constant, imem_req=0, fetch_count unchanged.
  - Raise rf_ready: the next fetch starts the following cycle.
- Redirect:
  - Redirect to 32'h0000_0200 in HOLD, same cycle as rf_ready: if_valid=0, fetch_count increments, next imem_addr=32'h200.
  - Redirect during FETCH with coincident ack: that word is never presented.
- Misaligned redirect to 32'h202: fault=1, imem_req stays 0 and if_valid stays 0 indefinitely; rst_n low for one edge clears fault and restarts at RESET_PC.
- Wrap:
  - With pc=32'hFFFF_FFFC: if_pc_plus4=32'h0 and the next imem_addr=32'h0.
  - With fetch_count preloaded near 2^32-1 via repeated accepts: it wraps to 0.
